sram_arbiter: RTL and testbench

- Shares the single external 8-bit, 21-bit-address SRAM of the next186 system between three requesters: ioctl download (ROM/disk image loading), video fetch, and CPU/system bus.
- Sequences each SRAM cycle through setup, strobe and hold phases.
- Drives SRAM_A, SRAM_WE_n and split data lines. The top-level instantiates the tristate on SRAM_D from sram_dout/sram_doe.

---
 rtl/sram_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single external next186 SRAM (8-bit data, 21-bit address)
// between ioctl download writes, video fetch reads and CPU/system bus accesses.
// Each access runs SETUP, ACCESS_CYCLES x STROBE, then HOLD. All outputs are registered.
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter logic [20:0] IOCTL_BASE    = 21'h000000
) (
    input  logic        clk_28_636,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,

    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,

    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        ioctl_ovf,

    output logic [20:0] SRAM_A,
    output logic        SRAM_WE_n,
    output logic [7:0]  sram_dout,
    output logic        sram_doe,
    input  logic [7:0]  sram_din,

    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IO   = 2'd1;
    localparam logic [1:0] OWN_VID  = 2'd2;
    localparam logic [1:0] OWN_CPU  = 2'd3;

    localparam logic [3:0] LAST_STROBE = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] STREAK_MAX  = 4'(STARVE_LIMIT);

    logic [1:0]  state;
    logic [1:0]  owner;
    logic [1:0]  sel;
    logic [3:0]  strobe_cnt;
    logic [3:0]  streak;
    logic        we_r;

    logic        io_pend;
    logic [20:0] io_addr;
    logic [7:0]  io_data;
    logic        io_done;

    logic        cpu_elig;
    logic        cpu_forced;

    // Upper download address bits select nothing inside the 2 MB SRAM window.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^ioctl_addr[24:21];

    assign ioctl_wait = io_pend;
    assign cpu_elig   = cpu_req && !ioctl_download;
    assign cpu_forced = cpu_elig && (streak == STREAK_MAX);
    assign io_done    = (state == ST_HOLD) && (owner == OWN_IO);

    // Fixed priority: pending ioctl, starved CPU, video, CPU.
    always_comb begin
        sel = OWN_NONE;
        if (io_pend)
            sel = OWN_IO;
        else if (cpu_forced)
            sel = OWN_CPU;
        else if (vid_req)
            sel = OWN_VID;
        else if (cpu_elig)
            sel = OWN_CPU;
    end

    // Single-entry ioctl write buffer; a strobe landing on the completing HOLD refills it.
    always_ff @(posedge clk_28_636) begin
        if (reset) begin
            io_pend   <= 1'b0;
            io_addr   <= '0;
            io_data   <= '0;
            ioctl_ovf <= 1'b0;
        end else begin
            if (io_done)
                io_pend <= 1'b0;
            if (ioctl_wr) begin
                if (!io_pend || io_done) begin
                    io_addr <= IOCTL_BASE + ioctl_addr[20:0];
                    io_data <= ioctl_dout;
                    io_pend <= 1'b1;
                end else begin
                    ioctl_ovf <= 1'b1;
                end
            end
        end
    end

    // Counts consecutive video grants taken while the CPU is left waiting.
    always_ff @(posedge clk_28_636) begin
        if (reset) begin
            streak <= '0;
        end else if (state == ST_IDLE) begin
            if (!cpu_elig || sel == OWN_CPU)
                streak <= '0;
            else if (sel == OWN_VID && streak != STREAK_MAX)
                streak <= streak + 4'd1;
        end
    end

    // Access sequencer driving the SRAM pins, acks and read-data registers.
    always_ff @(posedge clk_28_636) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            strobe_cnt <= '0;
            we_r       <= 1'b0;
            SRAM_A     <= '0;
            SRAM_WE_n  <= 1'b1;
            sram_dout  <= '0;
            sram_doe   <= 1'b0;
            busy       <= 1'b0;
            cpu_ack    <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_rdata  <= '0;
            vid_rdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sram_doe  <= 1'b0;
                    SRAM_WE_n <= 1'b1;
                    if (sel != OWN_NONE) begin
                        state <= ST_SETUP;
                        busy  <= 1'b1;
                        owner <= sel;
                        case (sel)
                            OWN_IO: begin
                                SRAM_A    <= io_addr;
                                sram_dout <= io_data;
                                we_r      <= 1'b1;
                                sram_doe  <= 1'b1;
                            end
                            OWN_VID: begin
                                SRAM_A   <= vid_addr;
                                we_r     <= 1'b0;
                                sram_doe <= 1'b0;
                            end
                            default: begin
                                SRAM_A    <= cpu_addr;
                                sram_dout <= cpu_wdata;
                                we_r      <= cpu_we;
                                sram_doe  <= cpu_we;
                            end
                        endcase
                    end
                end
                ST_SETUP: begin
                    state      <= ST_STROBE;
                    strobe_cnt <= '0;
                    SRAM_WE_n  <= !we_r;
                end
                ST_STROBE: begin
                    if (strobe_cnt == LAST_STROBE) begin
                        state     <= ST_HOLD;
                        SRAM_WE_n <= 1'b1;
                        if (owner == OWN_CPU) begin
                            cpu_ack <= 1'b1;
                            if (!we_r)
                                cpu_rdata <= sram_din;
                        end
                        if (owner == OWN_VID) begin
                            vid_ack   <= 1'b1;
                            vid_rdata <= sram_din;
                        end
                    end else begin
                        strobe_cnt <= strobe_cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    sram_doe  <= 1'b0;
                    SRAM_WE_n <= 1'b1;
                    owner     <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors with hand-computed expectations for sram_arbiter,
// using a behavioural SRAM that writes on low SRAM_WE_n and returns registered read data.
module tb_sram_arbiter;

    logic        clk_28_636 = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        vid_req;
    logic [20:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait, ioctl_ovf;
    logic [20:0] SRAM_A;
    logic        SRAM_WE_n;
    logic [7:0]  sram_dout;
    logic        sram_doe;
    logic [7:0]  sram_din;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int we_low_cnt  = 0;
    int cpu_ack_cnt = 0;

    logic [7:0] mem [logic [20:0]];

    sram_arbiter #(
        .ACCESS_CYCLES(2),
        .STARVE_LIMIT (4),
        .IOCTL_BASE   (21'h000000)
    ) dut (
        .clk_28_636    (clk_28_636),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ack       (cpu_ack),
        .cpu_rdata     (cpu_rdata),
        .vid_req       (vid_req),
        .vid_addr      (vid_addr),
        .vid_ack       (vid_ack),
        .vid_rdata     (vid_rdata),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .ioctl_ovf     (ioctl_ovf),
        .SRAM_A        (SRAM_A),
        .SRAM_WE_n     (SRAM_WE_n),
        .sram_dout     (sram_dout),
        .sram_doe      (sram_doe),
        .sram_din      (sram_din),
        .busy          (busy)
    );

    always #5 clk_28_636 = ~clk_28_636;

    function automatic logic [7:0] mem_rd(input logic [20:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // SRAM model: write while strobed, registered read of the current address.
    always @(posedge clk_28_636) begin
        if (!SRAM_WE_n && sram_doe)
            mem[SRAM_A] = sram_dout;
        sram_din <= mem_rd(SRAM_A);
    end

    // Activity counters sampled mid-cycle.
    always @(negedge clk_28_636) begin
        if (!SRAM_WE_n)
            we_low_cnt <= we_low_cnt + 1;
        if (cpu_ack)
            cpu_ack_cnt <= cpu_ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_28_636);
        #1;
    endtask

    task automatic wait_ack(input bit cpu, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(cpu ? cpu_ack : vid_ack) && n < limit);
    endtask

    initial begin
        int n;
        int base_we;
        int base_ack;
        logic [31:0] seq;
        int acks;

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 0; vid_addr = 21'h000200;
        ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_dout = '0;
        mem[21'h000200] = 8'h5A;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_we_n",  SRAM_WE_n,  1'b1);
        check("rst_doe",   sram_doe,   1'b0);
        check("rst_addr",  SRAM_A,     21'h0);
        check("rst_dout",  sram_dout,  8'h00);
        check("rst_acks",  {cpu_ack, vid_ack}, 2'b00);
        check("rst_rdata", {cpu_rdata, vid_rdata}, 16'h0000);
        check("rst_wait",  {ioctl_wait, ioctl_ovf}, 2'b00);
        check("rst_busy",  busy,       1'b0);

        // CPU write: grant in cycle 0, WE_n low cycles 2-3, ack cycle 4
        base_we = we_low_cnt;
        cpu_req = 1; cpu_we = 1; cpu_addr = 21'h000100; cpu_wdata = 8'hA5;
        tick();
        check("wr_setup_busy", busy, 1'b1);
        check("wr_setup_addr", SRAM_A, 21'h000100);
        check("wr_setup_pins", {SRAM_WE_n, sram_doe, sram_dout}, {1'b1, 1'b1, 8'hA5});
        tick();
        check("wr_strobe1_we_n", SRAM_WE_n, 1'b0);
        tick();
        check("wr_strobe2_we_n", SRAM_WE_n, 1'b0);
        check("wr_strobe2_ack", cpu_ack, 1'b0);
        tick();
        check("wr_hold", {SRAM_WE_n, sram_doe, cpu_ack}, 3'b111);
        cpu_req = 0;
        tick();
        check("wr_idle", {cpu_ack, busy, sram_doe}, 3'b000);
        check("wr_we_low_cycles", we_low_cnt - base_we, 2);
        check("wr_mem", mem_rd(21'h000100), 8'hA5);

        // CPU read back
        base_we = we_low_cnt;
        cpu_req = 1; cpu_we = 0;
        wait_ack(1, 10, n);
        check("rd_latency", n, 4);
        check("rd_data", cpu_rdata, 8'hA5);
        cpu_req = 0;
        tick();
        check("rd_no_we", we_low_cnt - base_we, 0);
        tick();

        // Priority: pending ioctl, then video, then CPU
        ioctl_wr = 1; ioctl_addr = 25'h0000010; ioctl_dout = 8'h3C;
        tick();
        ioctl_wr = 0;
        check("pri_wait_up", ioctl_wait, 1'b1);
        cpu_req = 1; cpu_we = 0; vid_req = 1;
        tick();
        check("pri_io_addr", SRAM_A, 21'h000010);
        check("pri_io_data", {sram_doe, sram_dout}, {1'b1, 8'h3C});
        n = 0;
        do begin
            tick();
            n++;
            if (cpu_ack || vid_ack)
                check("pri_early_ack", {cpu_ack, vid_ack}, 2'b00);
        end while (ioctl_wait && n < 10);
        check("pri_wait_fall", n, 4);
        check("pri_io_mem", mem_rd(21'h000010), 8'h3C);
        wait_ack(0, 10, n);
        check("pri_vid_second", n, 4);
        check("pri_vid_cpu_quiet", cpu_ack, 1'b0);
        check("pri_vid_data", vid_rdata, 8'h5A);
        vid_req = 0;
        wait_ack(1, 10, n);
        check("pri_cpu_third", n, 5);
        check("pri_cpu_data", cpu_rdata, 8'hA5);
        cpu_req = 0;
        repeat (2) tick();

        // Starvation: 4 video grants then one forced CPU grant, repeating
        cpu_req = 1; cpu_we = 0; vid_req = 1;
        seq = '0; acks = 0; n = 0;
        while (acks < 10 && n < 80) begin
            tick();
            n++;
            if (cpu_ack || vid_ack) begin
                seq = {seq[30:0], cpu_ack};
                acks++;
            end
        end
        cpu_req = 0; vid_req = 0;
        check("starve_ack_count", acks, 10);
        check("starve_pattern", seq & 32'h3FF, 32'h021);
        repeat (3) tick();

        // Download blocks the CPU
        ioctl_download = 1;
        cpu_req = 1; cpu_we = 0;
        base_ack = cpu_ack_cnt;
        repeat (100) tick();
        check("dl_no_cpu_ack", cpu_ack_cnt - base_ack, 0);
        check("dl_idle", busy, 1'b0);
        ioctl_download = 0;
        wait_ack(1, 6, n);
        check("dl_release_latency", n, 4);
        cpu_req = 0;
        repeat (2) tick();

        // Overflow: second strobe two cycles later is dropped
        base_we = we_low_cnt;
        ioctl_wr = 1; ioctl_addr = 25'h0000020; ioctl_dout = 8'h11;
        tick();
        ioctl_wr = 0;
        tick();
        ioctl_wr = 1; ioctl_addr = 25'h0000021; ioctl_dout = 8'h22;
        tick();
        ioctl_wr = 0;
        check("ovf_set", ioctl_ovf, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (ioctl_wait && n < 12);
        check("ovf_wait_fall", n, 3);
        repeat (3) tick();
        check("ovf_sticky", ioctl_ovf, 1'b1);
        check("ovf_first_written", mem_rd(21'h000020), 8'h11);
        check("ovf_second_dropped", mem.exists(21'h000021), 1'b0);
        check("ovf_one_write", we_low_cnt - base_we, 2);

        // Reset during the STROBE of a CPU write with an ioctl write pending
        base_ack = cpu_ack_cnt;
        cpu_req = 1; cpu_we = 1; cpu_addr = 21'h000300; cpu_wdata = 8'h77;
        tick();
        ioctl_wr = 1; ioctl_addr = 25'h0000040; ioctl_dout = 8'h99;
        tick();
        ioctl_wr = 0;
        check("mid_strobe", {SRAM_WE_n, ioctl_wait}, 2'b01);
        reset = 1; cpu_req = 0;
        tick();
        check("mid_rst_pins", {SRAM_WE_n, sram_doe, busy}, 3'b100);
        check("mid_rst_wait", {ioctl_wait, ioctl_ovf}, 2'b00);
        check("mid_rst_ack", cpu_ack, 1'b0);
        reset = 0;
        repeat (10) tick();
        check("mid_rst_no_ack", cpu_ack_cnt - base_ack, 0);
        check("mid_rst_no_io", mem.exists(21'h000040), 1'b0);
        check("mid_rst_quiet", {busy, ioctl_wait}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
